// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - mode-0 MSB-first SPI controller, one full-duplex word per valid/ready handshake
module spi_controller #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_srst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_dataTx,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_dataRx,
    output logic              o_rxValid,
    output logic              o_sck,
    output logic              o_csn,
    output logic              o_sdo,
    input  logic              i_sdi
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_SHIFT,
        S_TRAIL
    } state_t;

    state_t              state, state_n;
    logic [DIV_W-1:0]    div_cnt, div_cnt_n;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0]   tx_sh, tx_sh_n;
    logic [DATA_W-1:0]   rx_sh, rx_sh_n;
    logic [DATA_W-1:0]   data_rx_n;
    logic                ready_n, rx_valid_n, sck_n, csn_n, sdo_n;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            o_ready   <= 1'b1;
            o_dataRx  <= '0;
            o_rxValid <= 1'b0;
            o_sck     <= 1'b0;
            o_csn     <= 1'b1;
            o_sdo     <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_cnt_n;
            bit_cnt   <= bit_cnt_n;
            tx_sh     <= tx_sh_n;
            rx_sh     <= rx_sh_n;
            o_ready   <= ready_n;
            o_dataRx  <= data_rx_n;
            o_rxValid <= rx_valid_n;
            o_sck     <= sck_n;
            o_csn     <= csn_n;
            o_sdo     <= sdo_n;
        end
    end

    // Every output is computed here as a next value, so all outputs leave the block registered.
    always_comb begin
        state_n    = state;
        div_cnt_n  = div_cnt;
        bit_cnt_n  = bit_cnt;
        tx_sh_n    = tx_sh;
        rx_sh_n    = rx_sh;
        ready_n    = o_ready;
        data_rx_n  = o_dataRx;
        rx_valid_n = 1'b0;
        sck_n      = o_sck;
        csn_n      = o_csn;
        sdo_n      = o_sdo;

        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                csn_n   = 1'b1;
                sck_n   = 1'b0;
                if (i_valid && o_ready) begin
                    tx_sh_n   = i_dataTx;
                    rx_sh_n   = '0;
                    div_cnt_n = '0;
                    bit_cnt_n = '0;
                    sdo_n     = i_dataTx[DATA_W-1];
                    ready_n   = 1'b0;
                    csn_n     = 1'b0;
                    state_n   = S_LEAD;
                end
            end
            S_LEAD: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    state_n   = S_SHIFT;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n = '0;
                    if (!o_sck) begin
                        // Rising edge: capture now, the peripheral drove its bit a half-period ago.
                        sck_n   = 1'b1;
                        rx_sh_n = {rx_sh[DATA_W-2:0], i_sdi};
                    end else begin
                        sck_n   = 1'b0;
                        tx_sh_n = {tx_sh[DATA_W-2:0], 1'b0};
                        sdo_n   = tx_sh[DATA_W-2];
                        if (bit_cnt == BIT_LAST) begin
                            state_n = S_TRAIL;
                        end else begin
                            bit_cnt_n = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            S_TRAIL: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_n  = '0;
                    data_rx_n  = rx_sh;
                    rx_valid_n = 1'b1;
                    csn_n      = 1'b1;
                    ready_n    = 1'b1;
                    state_n    = S_IDLE;
                end else begin
                    div_cnt_n = div_cnt + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - directed self-checking bench for spi_controller (DATA_W=8, CLK_DIV=2)
module tb_spi_controller;

    logic       clk = 1'b0;
    logic       srst;
    logic       valid;
    logic [7:0] data_tx;
    logic       ready;
    logic [7:0] data_rx;
    logic       rx_valid;
    logic       sck;
    logic       csn;
    logic       sdo;
    logic       sdi;

    logic       loopback;
    logic       per_load;
    logic [7:0] per_init;
    logic [7:0] per_tx;
    logic [7:0] per_rx;
    logic [7:0] sdo_hist;
    int         rise_cnt = 0;

    int n_cmp = 0;
    int n_bad = 0;

    spi_controller #(.DATA_W(8), .CLK_DIV(2)) dut (
        .i_clk     (clk),
        .i_srst    (srst),
        .i_valid   (valid),
        .i_dataTx  (data_tx),
        .o_ready   (ready),
        .o_dataRx  (data_rx),
        .o_rxValid (rx_valid),
        .o_sck     (sck),
        .o_csn     (csn),
        .o_sdo     (sdo),
        .i_sdi     (sdi)
    );

    always #5 clk = ~clk;

    assign sdi = loopback ? sdo : per_tx[7];

    always @(posedge sck) begin
        rise_cnt <= rise_cnt + 1;
        sdo_hist <= {sdo_hist[6:0], sdo};
    end

    // Mode-0 peripheral: shifts its output on falling SCK, samples on rising SCK.
    always @(negedge sck or posedge per_load) begin
        if (per_load) per_tx <= per_init;
        else          per_tx <= {per_tx[6:0], 1'b0};
    end

    always @(posedge sck or posedge per_load) begin
        if (per_load) per_rx <= '0;
        else          per_rx <= {per_rx[6:0], sdo};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        srst     = 1'b1;
        loopback = 1'b1;
        per_load = 1'b0;
        per_init = 8'h00;
        for (int i = 0; i < 3; i++) begin
            valid   = 1'($urandom);
            data_tx = 8'($urandom);
            tick();
        end
        n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL rst_ready: got %b expected 1", ready); end
        n_cmp++; if (sck !== 1'b0)       begin n_bad++; $display("FAIL rst_sck: got %b expected 0", sck); end
        n_cmp++; if (csn !== 1'b1)       begin n_bad++; $display("FAIL rst_csn: got %b expected 1", csn); end
        n_cmp++; if (sdo !== 1'b0)       begin n_bad++; $display("FAIL rst_sdo: got %b expected 0", sdo); end
        n_cmp++; if (rx_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_rxvalid: got %b expected 0", rx_valid); end
        n_cmp++; if (data_rx !== 8'h00)  begin n_bad++; $display("FAIL rst_datarx: got %h expected 00", data_rx); end
        srst  = 1'b0;
        valid = 1'b0;
        tick();
    endtask

    task automatic test_loopback;
        int base, csn_first, csn_last, csn_low, rxv_n, rxv_at;
        csn_first = -1; csn_last = -1; csn_low = 0; rxv_n = 0; rxv_at = -1;
        loopback = 1'b1;
        base     = rise_cnt;
        valid    = 1'b1;
        data_tx  = 8'hA5;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL loop_accept_ready: got %b expected 1", ready); end
        tick();
        valid   = 1'b0;
        data_tx = 8'h00;
        for (int c = 1; c <= 45; c++) begin
            if (csn === 1'b0) begin
                if (csn_first < 0) csn_first = c;
                csn_last = c;
                csn_low++;
            end
            if (rx_valid === 1'b1) begin
                rxv_n++;
                rxv_at = c;
            end
            tick();
        end
        n_cmp++; if (csn_first != 1)     begin n_bad++; $display("FAIL loop_csn_first: got %0d expected 1", csn_first); end
        n_cmp++; if (csn_last != 36)     begin n_bad++; $display("FAIL loop_csn_last: got %0d expected 36", csn_last); end
        n_cmp++; if (csn_low != 36)      begin n_bad++; $display("FAIL loop_csn_low_cycles: got %0d expected 36", csn_low); end
        n_cmp++; if (rxv_n != 1)         begin n_bad++; $display("FAIL loop_rxvalid_count: got %0d expected 1", rxv_n); end
        n_cmp++; if (rxv_at != 37)       begin n_bad++; $display("FAIL loop_rxvalid_cycle: got %0d expected 37", rxv_at); end
        n_cmp++; if (data_rx !== 8'hA5)  begin n_bad++; $display("FAIL loop_datarx: got %h expected a5", data_rx); end
        n_cmp++; if (rise_cnt - base != 8) begin n_bad++; $display("FAIL loop_sck_rises: got %0d expected 8", rise_cnt - base); end
    endtask

    task automatic test_peripheral;
        loopback = 1'b0;
        per_init = 8'h3C;
        per_load = 1'b1;
        #1;
        per_load = 1'b0;
        valid    = 1'b1;
        data_tx  = 8'h96;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 60 && rx_valid !== 1'b1; i++) tick();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL per_timeout: rxvalid got %b expected 1", rx_valid); end
        n_cmp++; if (data_rx !== 8'h3C) begin n_bad++; $display("FAIL per_datarx: got %h expected 3c", data_rx); end
        n_cmp++; if (per_rx !== 8'h96)  begin n_bad++; $display("FAIL per_received: got %h expected 96", per_rx); end
        tick();
        loopback = 1'b1;
    endtask

    task automatic test_back_to_back;
        int base, nw, csn_hi, at0, at1, w0, w1, rdy_at_first;
        nw = 0; csn_hi = 0; at0 = -1; at1 = -1; w0 = -1; w1 = -1; rdy_at_first = -1;
        loopback = 1'b1;
        base     = rise_cnt;
        valid    = 1'b1;
        data_tx  = 8'h01;
        tick();
        data_tx = 8'hFF;
        for (int c = 1; c <= 80; c++) begin
            if (c < 74 && csn === 1'b1) csn_hi++;
            if (rx_valid === 1'b1) begin
                if (nw == 0) begin
                    w0 = int'(data_rx); at0 = c; rdy_at_first = int'(ready);
                end else if (nw == 1) begin
                    w1 = int'(data_rx); at1 = c;
                    valid = 1'b0;
                end
                nw++;
            end
            tick();
        end
        valid = 1'b0;
        n_cmp++; if (nw != 2)         begin n_bad++; $display("FAIL b2b_word_count: got %0d expected 2", nw); end
        n_cmp++; if (w0 != 'h01)      begin n_bad++; $display("FAIL b2b_word0: got %0h expected 01", w0); end
        n_cmp++; if (w1 != 'hFF)      begin n_bad++; $display("FAIL b2b_word1: got %0h expected ff", w1); end
        n_cmp++; if (at0 != 37)       begin n_bad++; $display("FAIL b2b_first_rxvalid: got %0d expected 37", at0); end
        n_cmp++; if (rdy_at_first != 1) begin n_bad++; $display("FAIL b2b_ready_with_rxvalid: got %0d expected 1", rdy_at_first); end
        n_cmp++; if (at1 != 74)       begin n_bad++; $display("FAIL b2b_second_rxvalid: got %0d expected 74", at1); end
        n_cmp++; if (csn_hi != 1)     begin n_bad++; $display("FAIL b2b_csn_high_cycles: got %0d expected 1", csn_hi); end
        n_cmp++; if (rise_cnt - base != 16) begin n_bad++; $display("FAIL b2b_sck_rises: got %0d expected 16", rise_cnt - base); end
    endtask

    task automatic test_busy_changes;
        int base, rxv_n;
        rxv_n    = 0;
        loopback = 1'b1;
        base     = rise_cnt;
        valid    = 1'b1;
        data_tx  = 8'hC3;
        tick();
        valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            valid = 1'b0;
            if (c == 5) begin
                valid   = 1'b1;
                data_tx = 8'h00;
                n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready_low: got %b expected 0", ready); end
            end
            if (c == 12) data_tx = 8'hFF;
            if (rx_valid === 1'b1) rxv_n++;
            tick();
        end
        valid = 1'b0;
        n_cmp++; if (sdo_hist !== 8'hC3)   begin n_bad++; $display("FAIL busy_sdo_bits: got %b expected 11000011", sdo_hist); end
        n_cmp++; if (rise_cnt - base != 8) begin n_bad++; $display("FAIL busy_sck_rises: got %0d expected 8", rise_cnt - base); end
        n_cmp++; if (rxv_n != 1)           begin n_bad++; $display("FAIL busy_rxvalid_count: got %0d expected 1", rxv_n); end
        n_cmp++; if (data_rx !== 8'hC3)    begin n_bad++; $display("FAIL busy_datarx: got %h expected c3", data_rx); end
    endtask

    task automatic test_reset_mid;
        int base, rxv_n;
        rxv_n    = 0;
        loopback = 1'b1;
        base     = rise_cnt;
        valid    = 1'b1;
        data_tx  = 8'h33;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 40 && (rise_cnt - base) < 3; i++) tick();
        n_cmp++; if (rise_cnt - base != 3) begin n_bad++; $display("FAIL mid_third_rise: got %0d expected 3", rise_cnt - base); end
        srst  = 1'b1;
        valid = 1'b1;
        tick();
        srst  = 1'b0;
        valid = 1'b0;
        n_cmp++; if (sck !== 1'b0)      begin n_bad++; $display("FAIL mid_sck: got %b expected 0", sck); end
        n_cmp++; if (csn !== 1'b1)      begin n_bad++; $display("FAIL mid_csn: got %b expected 1", csn); end
        n_cmp++; if (ready !== 1'b1)    begin n_bad++; $display("FAIL mid_ready: got %b expected 1", ready); end
        n_cmp++; if (sdo !== 1'b0)      begin n_bad++; $display("FAIL mid_sdo: got %b expected 0", sdo); end
        for (int c = 0; c < 50; c++) begin
            if (rx_valid !== 1'b0) rxv_n++;
            tick();
        end
        n_cmp++; if (rxv_n != 0)        begin n_bad++; $display("FAIL mid_no_rxvalid: got %0d expected 0", rxv_n); end
        valid   = 1'b1;
        data_tx = 8'h5A;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 60 && rx_valid !== 1'b1; i++) tick();
        n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL mid_after_timeout: rxvalid got %b expected 1", rx_valid); end
        n_cmp++; if (data_rx !== 8'h5A) begin n_bad++; $display("FAIL mid_after_datarx: got %h expected 5a", data_rx); end
    endtask

    initial begin
        srst     = 1'b1;
        valid    = 1'b0;
        data_tx  = 8'h00;
        loopback = 1'b1;
        per_load = 1'b0;
        per_init = 8'h00;
        test_reset();
        test_loopback();
        test_peripheral();
        test_back_to_back();
        test_busy_changes();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
# spi_controller

Synchronous SPI controller (mode 0, MSB first) on the local system clock. It generates SCK, CS_n and SDO for one SPI peripheral and captures the peripheral's SDO. It sits directly upstream of the SPI peripheral: `o_sck` drives the peripheral's `i_sck`, `o_sdo` drives its `i_sdi`, and `i_sdi` comes from its `o_sdo`. Each accepted word is exactly one `DATA_W`-bit full-duplex transfer, with a valid/ready handshake on the system side.

## Interface
- `DATA_W`, default 8: word width in bits. Must be ≥2.
- `CLK_DIV`, default 4: system clocks per SCK half-period. Must be ≥1.
- `i_clk` input, 1: system clock. The only clock in the block.
- `i_srst` input, 1: reset. Synchronous, active-high.
- `i_valid` input, 1: request to start a transfer of `i_dataTx`.
- `i_dataTx` input, `DATA_W`: word to send. Sampled only on the accept cycle.
- `o_ready` output, 1: controller idle; `i_valid` is accepted this cycle.
- `o_dataRx` output, `DATA_W`: last received word. Holds until the next completion.
- `o_rxValid` output, 1: one-cycle pulse when `o_dataRx` updates.
- `o_sck` output, 1: serial clock. Idles low.
- `o_csn` output, 1: chip select, active low.
- `o_sdo` output, 1: serial data to the peripheral.
- `i_sdi` input, 1: serial data from the peripheral.

## Operation
- All outputs are registered; there are no combinational input-to-output paths.
- Reset values: `o_ready`=1, `o_sck`=0, `o_csn`=1, `o_sdo`=0, `o_rxValid`=0, `o_dataRx`=0. State goes to IDLE and all counters clear.
- State machine IDLE → LEAD → SHIFT → TRAIL → IDLE.
- **IDLE**
  - `o_ready`=1, `o_csn`=1, `o_sck`=0.
  - Accept on `i_valid && o_ready`: load the tx shift register with `i_dataTx` and clear the rx shift register, `divCnt` and `bitCnt`.
  - Go to LEAD. `o_sdo` = `i_dataTx[DATA_W-1]` from the next cycle.
- **LEAD**
  - `o_csn`=0, `o_sck`=0, `o_ready`=0.
  - Lasts `CLK_DIV` cycles, which is the CS-to-first-edge setup time. Then go to SHIFT.
- **SHIFT**
  - `divCnt` counts 0..`CLK_DIV`-1 and wraps; each wrap ends one half-period.
  - End of a low half:
    - `o_sck` goes 1.
    - In the same cycle, shift `i_sdi` into the rx register LSB.
  - End of a high half:
    - `o_sck` goes 0.
    - Shift the tx register left; `o_sdo` takes the new MSB.
    - `bitCnt` increments.
  - After the `DATA_W`-th falling edge (`bitCnt`==`DATA_W`-1 at the fall), go to TRAIL.
  - Exactly `DATA_W` rising edges are produced per word. The peripheral frames words by counting edges and has no CS, so partial words are forbidden.
- **TRAIL**
  - `o_csn`=0, `o_sck`=0, lasting `CLK_DIV` cycles.
  - On exit:
    - `o_dataRx` ← rx register.
    - `o_rxValid`=1 for one cycle.
    - `o_csn`=1, `o_ready`=1, state IDLE.
- Widths:
  - `divCnt` is `max(1,$clog2(CLK_DIV))` bits.
  - `bitCnt` is `$clog2(DATA_W)` bits and never exceeds `DATA_W`-1.
  - The comparisons are exact; there is no free-running wrap.
- `i_valid` while `o_ready`=0 is ignored; there is no queue.
- Changes to `i_dataTx` during a transfer have no effect.
- Reset mid-operation (any state):
  - On the next cycle, outputs take their reset values.
  - The in-flight word is discarded and no `o_rxValid` is issued.
  - The system must also reset the peripheral (its `i_arst`) to re-align its bit counter.

## Timing
- Accept at clock edge 0.
  - LEAD occupies cycles 1..`CLK_DIV`.
  - SHIFT occupies the next `2·DATA_W·CLK_DIV` cycles.
  - TRAIL occupies the next `CLK_DIV` cycles.
  - `o_rxValid`=1 and `o_ready`=1 in cycle `(2·DATA_W+2)·CLK_DIV + 1`.
- SCK period is `2·CLK_DIV` system clocks at 50% duty.
- `o_sdo` changes only in the cycle `o_sck` falls, or on load, so it is stable across each rising edge.
- `i_sdi` is sampled in the cycle `o_sck` rises. The peripheral changes its SDO on SCK falling edges, which gives a half-period of setup.
- Back-to-back operation:
  - `i_valid` may be accepted in the same cycle as `o_rxValid`.
  - `o_csn` is high for exactly 1 cycle between words.
  - Minimum word spacing is `(2·DATA_W+2)·CLK_DIV + 1` cycles.
- If `i_srst` and `i_valid` are both high in the same cycle, reset wins and nothing is accepted.

## Test plan
All scenarios use `DATA_W`=8 and `CLK_DIV`=2.
- **Reset values:** hold `i_srst` 3 cycles with random inputs → `o_ready`=1, `o_sck`=0, `o_csn`=1, `o_sdo`=0, `o_rxValid`=0, `o_dataRx`=0x00.
- **Loopback:** tie `o_sdo`→`i_sdi`, send 0xA5 at cycle 0 → exactly 8 SCK rises; `o_rxValid` pulses in cycle 37 only; `o_dataRx`=0xA5; `o_csn` low in cycles 1..36.
- **Peripheral model:** connect a mode-0 peripheral model loaded with 0x3C; controller sends 0x96 → `o_dataRx`=0x3C; peripheral receives 0x96.
- **Back-to-back:** hold `i_valid`=1 and present 0x01 then 0xFF in loopback → second word is accepted in the `o_rxValid` cycle of the first; `o_csn` is high for 1 cycle; the two received words are 0x01 and 0xFF; 16 SCK rises total.
- **Busy-time changes:** pulse `i_valid` with 0x00 while busy, and change `i_dataTx` mid-transfer of 0xC3 → both ignored; SDO bit sequence is 1,1,0,0,0,0,1,1; one `o_rxValid`.
- **Reset mid-transfer:** assert `i_srst` after the 3rd SCK rise → next cycle `o_sck`=0, `o_csn`=1, `o_ready`=1, and no `o_rxValid`; then send 0x5A in loopback → `o_dataRx`=0x5A.
